pc_mux_pipe: RTL and testbench

PC_MUX_PIPE -- requirements
Module: pc_mux_pipe

---
 rtl/pc_mux_pipe.sv | 160 ++++++++++++++++
 tb/tb_pc_mux_pipe.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_mux_pipe.sv
// ---------------------------------------------------------------------------
// pc_mux_pipe
//
// This module selects one of NUM_IN valid/ready input channels and places the
// chosen word in a single registered output stage. The output stage runs at
// full throughput: a word can be taken and replaced in the same cycle.
//
// Channel choice depends on the mode input:
//   - mode = 0: explicit selection through sel. If sel is not a valid channel
//     number, no transfer happens and sel_err pulses on the next cycle.
//   - mode = 1: round-robin arbitration. Scanning starts at rr_ptr, and the
//     pointer moves past the winning channel after each arbitrated transfer.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous, active-low reset
//   in_data    packed channel words; channel i is at [i*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel ready (combinational; at most one bit is set)
//   sel        explicit channel select (used when mode = 0)
//   mode       0 = explicit select, 1 = round-robin
//   out_data   registered selected word
//   out_valid  out_data holds a word that has not been taken yet
//   out_ready  downstream accepts out_data this cycle
//   sel_err    registered one-cycle flag for an out-of-range select
//   xfer_cnt   wrapping count of accepted input transfers
// ---------------------------------------------------------------------------
module pc_mux_pipe #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    mode,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    sel_err,
    output logic [15:0]             xfer_cnt
);

    logic [WIDTH-1:0] chan_word [NUM_IN];

    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             sel_err_q,   sel_err_d;
    logic [15:0]      xfer_cnt_q,  xfer_cnt_d;
    logic [SEL_W-1:0] rr_ptr_q,    rr_ptr_d;

    logic             load_en;
    logic             sel_in_range;
    logic             grant_ok;
    logic [SEL_W-1:0] grant_idx;
    logic             xfer;

    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_unpack
        assign chan_word[gi] = in_data[gi*WIDTH +: WIDTH];
    end

    // The output register may load a new word when it is empty, or when its
    // current word is being taken in this same cycle.
    assign load_en      = !out_valid_q || out_ready;
    assign sel_in_range = (int'(sel) < NUM_IN);

    // Grant selection. In round-robin mode, the scan starts at rr_ptr and wraps
    // at NUM_IN. NUM_IN need not be a power of two, so the wrap is done
    // explicitly rather than by letting the pointer overflow.
    always_comb begin
        int               idx;
        logic [SEL_W-1:0] idx_w;
        logic             found;

        idx       = 0;
        idx_w     = '0;
        found     = 1'b0;
        grant_ok  = 1'b0;
        grant_idx = '0;

        if (!mode) begin
            grant_ok  = sel_in_range;
            grant_idx = sel;
        end else begin
            for (int k = 0; k < NUM_IN; k++) begin
                idx = int'(rr_ptr_q) + k;
                if (idx >= NUM_IN) begin
                    idx = idx - NUM_IN;
                end
                idx_w = SEL_W'(idx);
                if (!found && in_valid[idx_w]) begin
                    found     = 1'b1;
                    grant_idx = idx_w;
                end
            end
            grant_ok = found;
        end
    end

    always_comb begin
        in_ready = '0;
        if (grant_ok && load_en) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    assign xfer = grant_ok && load_en && in_valid[grant_idx];

    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        xfer_cnt_d  = xfer_cnt_q;
        rr_ptr_d    = rr_ptr_q;
        sel_err_d   = !mode && !sel_in_range;

        if (xfer) begin
            // A transfer always wins. If the old word is taken in the same
            // cycle, it is replaced, so one word per cycle can flow through.
            out_data_d  = chan_word[grant_idx];
            out_valid_d = 1'b1;
            xfer_cnt_d  = xfer_cnt_q + 16'd1;
            if (mode) begin
                if (int'(grant_idx) == NUM_IN - 1) begin
                    rr_ptr_d = '0;
                end else begin
                    rr_ptr_d = grant_idx + SEL_W'(1);
                end
            end
        end else if (out_ready) begin
            // The word was taken and nothing replaces it. out_data keeps its
            // value; only the valid flag drops.
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            sel_err_q   <= 1'b0;
            xfer_cnt_q  <= '0;
            rr_ptr_q    <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            sel_err_q   <= sel_err_d;
            xfer_cnt_q  <= xfer_cnt_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign sel_err   = sel_err_q;
    assign xfer_cnt  = xfer_cnt_q;

endmodule

// File: tb/tb_pc_mux_pipe.sv
// ---------------------------------------------------------------------------
// tb_pc_mux_pipe
//
// Testbench for pc_mux_pipe with two instances:
//   - dut: NUM_IN = 4. A cycle-level reference model tracks it. Every word the
//     model expects to be transferred is pushed into a scoreboard queue, and
//     it is popped and compared when the DUT's output word is taken.
//   - dut3: NUM_IN = 3. It is used for the out-of-range select cases and for
//     the counter wrap.
// ---------------------------------------------------------------------------
module tb_pc_mux_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Four-channel instance
    logic         rst_n;
    logic [127:0] in_data;
    logic [3:0]   in_valid;
    logic [3:0]   in_ready;
    logic [1:0]   sel;
    logic         mode;
    logic [31:0]  out_data;
    logic         out_valid;
    logic         out_ready;
    logic         sel_err;
    logic [15:0]  xfer_cnt;

    // Three-channel instance
    logic         rst3_n;
    logic [95:0]  in_data3;
    logic [2:0]   in_valid3;
    logic [2:0]   in_ready3;
    logic [1:0]   sel3;
    logic         mode3;
    logic [31:0]  out_data3;
    logic         out_valid3;
    logic         out_ready3;
    logic         sel_err3;
    logic [15:0]  xfer_cnt3;

    pc_mux_pipe #(.WIDTH(32), .NUM_IN(4), .SEL_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .mode      (mode),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sel_err   (sel_err),
        .xfer_cnt  (xfer_cnt)
    );

    pc_mux_pipe #(.WIDTH(32), .NUM_IN(3), .SEL_W(2)) dut3 (
        .clk       (clk),
        .rst_n     (rst3_n),
        .in_data   (in_data3),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .sel       (sel3),
        .mode      (mode3),
        .out_data  (out_data3),
        .out_valid (out_valid3),
        .out_ready (out_ready3),
        .sel_err   (sel_err3),
        .xfer_cnt  (xfer_cnt3)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit quiet    = 1'b0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model and scoreboard for the four-channel instance.
    // Inputs change at posedge+1. The model evaluates at negedge and commits
    // its state at the following posedge.
    logic [31:0] exp_q[$];
    bit          m_ov;
    logic [15:0] m_cnt;
    int          m_rr;

    initial begin : monitor
        bit         ld;
        bit         xf;
        int         g;
        logic [3:0] exp_rdy;
        logic [31:0] w;
        m_ov  = 1'b0;
        m_cnt = '0;
        m_rr  = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_ov  = 1'b0;
                m_cnt = '0;
                m_rr  = 0;
                exp_q.delete();
                continue;
            end
            ld = !m_ov || out_ready;
            g  = -1;
            if (!mode) begin
                g = int'(sel);
            end else begin
                for (int k = 0; k < 4; k++) begin
                    int c;
                    c = (m_rr + k) % 4;
                    if (g < 0 && in_valid[c]) g = c;
                end
            end
            exp_rdy = (g >= 0 && ld) ? (4'b0001 << g) : 4'b0000;
            check("in_ready", 32'(in_ready), 32'(exp_rdy));
            check("out_valid", 32'(out_valid), 32'(m_ov));
            check("xfer_cnt", 32'(xfer_cnt), 32'(m_cnt));
            check("sel_err", 32'(sel_err), 32'(1'b0));
            check("rr_ptr", 32'(dut.rr_ptr_q), 32'(m_rr));
            if (m_ov && out_ready) begin
                check("sb_nonempty", 32'(exp_q.size() > 0), 32'(1));
                if (exp_q.size() > 0) begin
                    w = exp_q.pop_front();
                    check("sb_out_data", out_data, w);
                    if (!quiet) $display("take: out_data=0x%0h expected=0x%0h", out_data, w);
                end
            end
            xf = (g >= 0) && ld && in_valid[g];
            if (xf) exp_q.push_back(in_data[g*32 +: 32]);
            @(posedge clk);
            if (rst_n) begin
                if (xf) begin
                    m_ov  = 1'b1;
                    m_cnt = m_cnt + 16'd1;
                    if (mode) m_rr = (g + 1) % 4;
                end else if (m_ov && out_ready) begin
                    m_ov = 1'b0;
                end
            end
        end
    end

    initial begin : stim
        rst_n = 1'b0; in_data = '0; in_valid = '0; sel = '0; mode = 1'b0; out_ready = 1'b0;
        rst3_n = 1'b0; in_data3 = '0; in_valid3 = '0; sel3 = '0; mode3 = 1'b0; out_ready3 = 1'b0;
        repeat (2) tick();
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_out_data", out_data, 32'h0);
        check("rst_xfer_cnt", 32'(xfer_cnt), 32'(0));
        check("rst_sel_err", 32'(sel_err), 32'(0));
        rst_n = 1'b1; rst3_n = 1'b1;

        // Explicit select of channel 2
        mode = 1'b0; sel = 2'd2; in_valid = 4'b0100; in_data[64 +: 32] = 32'h19; out_ready = 1'b1;
        #1 check("t1_in_ready", 32'(in_ready), 32'(4'b0100));
        tick();
        in_valid = '0;
        check("t1_out_data", out_data, 32'h19);
        check("t1_out_valid", 32'(out_valid), 32'(1));
        check("t1_xfer_cnt", 32'(xfer_cnt), 32'(1));
        tick();

        // Backpressure: hold 0x5 while 0xA waits on channel 1
        sel = 2'd1; in_valid = 4'b0010; in_data[32 +: 32] = 32'h5; out_ready = 1'b0;
        tick();
        in_data[32 +: 32] = 32'hA;
        for (int i = 0; i < 3; i++) begin
            mode = (i == 1);   // switching mode must not disturb the held word
            #1 check("bp_in_ready", 32'(in_ready), 32'(0));
            check("bp_hold_data", out_data, 32'h5);
            tick();
        end
        mode = 1'b0;
        check("bp_hold_data_end", out_data, 32'h5);
        out_ready = 1'b1;
        #1 check("bp_release_ready", 32'(in_ready), 32'(4'b0010));
        tick();
        in_valid = '0;
        check("bp_new_data", out_data, 32'hA);
        check("bp_out_valid", 32'(out_valid), 32'(1));
        check("bp_xfer_cnt", 32'(xfer_cnt), 32'(3));
        tick();

        // Round-robin from reset with every channel valid
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = 32'h100 + 32'(i);
        for (int k = 0; k < 7; k++) begin
            #1 check("rr_grant", 32'(in_ready), 32'(4'b0001 << (k % 4)));
            tick();
            check("rr_ptr_seq", 32'(dut.rr_ptr_q), 32'((k + 1) % 4));
        end
        // rr_ptr is now 3. Only channels 0 and 1 are valid, so the scan wraps to 0.
        in_valid = 4'b0011;
        #1 check("rr_wrap_grant0", 32'(in_ready), 32'(4'b0001));
        tick();
        check("rr_wrap_ptr1", 32'(dut.rr_ptr_q), 32'(1));
        #1 check("rr_wrap_grant1", 32'(in_ready), 32'(4'b0010));
        tick();
        check("rr_wrap_ptr2", 32'(dut.rr_ptr_q), 32'(2));
        in_valid = '0; mode = 1'b0;
        tick(); tick();

        // Three-channel instance: select 3 is out of range
        mode3 = 1'b0; sel3 = 2'd0; in_valid3 = 3'b001; in_data3[0 +: 32] = 32'h77; out_ready3 = 1'b0;
        tick();
        in_valid3 = '0;
        check("n3_pre_valid", 32'(out_valid3), 32'(1));
        check("n3_pre_cnt", 32'(xfer_cnt3), 32'(1));
        sel3 = 2'd3; in_valid3 = 3'b111;
        #1 check("n3_in_ready_hold", 32'(in_ready3), 32'(0));
        tick();
        sel3 = 2'd0; in_valid3 = '0;
        check("n3_sel_err_set", 32'(sel_err3), 32'(1));
        check("n3_out_valid", 32'(out_valid3), 32'(1));
        check("n3_out_data", out_data3, 32'h77);
        check("n3_cnt_same", 32'(xfer_cnt3), 32'(1));
        tick();
        check("n3_sel_err_clr", 32'(sel_err3), 32'(0));
        sel3 = 2'd3; in_valid3 = 3'b111; out_ready3 = 1'b1;
        #1 check("n3_in_ready_load", 32'(in_ready3), 32'(0));
        tick();
        sel3 = 2'd0; in_valid3 = '0;
        check("n3_sel_err_set2", 32'(sel_err3), 32'(1));
        check("n3_no_xfer_valid", 32'(out_valid3), 32'(0));
        check("n3_no_xfer_cnt", 32'(xfer_cnt3), 32'(1));
        tick();
        check("n3_sel_err_clr2", 32'(sel_err3), 32'(0));

        // Long stream: dut3 makes 0x10000 transfers and dut makes 0xFFFF
        rst_n = 1'b0; rst3_n = 1'b0; tick(); rst_n = 1'b1; rst3_n = 1'b1;
        quiet = 1'b1;
        mode3 = 1'b1; in_valid3 = 3'b111; out_ready3 = 1'b1;
        tick();
        mode = 1'b0; sel = 2'd0; in_valid = 4'b0001; in_data[0 +: 32] = 32'hDEADBEEF; out_ready = 1'b1;
        repeat (65535) tick();
        in_valid = '0; in_valid3 = '0; out_ready = 1'b0;
        quiet = 1'b0;
        check("wrap_cnt3", 32'(xfer_cnt3), 32'(0));
        check("pre_rst_cnt", 32'(xfer_cnt), 32'hFFFF);
        check("pre_rst_valid", 32'(out_valid), 32'(1));
        check("pre_rst_data", out_data, 32'hDEADBEEF);

        // Asynchronous reset in the middle of a clock cycle
        #2 rst_n = 1'b0;
        #1;
        check("async_out_data", out_data, 32'h0);
        check("async_out_valid", 32'(out_valid), 32'(0));
        check("async_xfer_cnt", 32'(xfer_cnt), 32'(0));
        check("async_sel_err", 32'(sel_err), 32'(0));
        check("async_rr_ptr", 32'(dut.rr_ptr_q), 32'(0));
        tick(); tick();
        rst_n = 1'b1;

        // The first cycle after reset release behaves as an empty output stage
        in_valid = 4'b0001; in_data[0 +: 32] = 32'h42; out_ready = 1'b0;
        #1 check("post_rst_ready", 32'(in_ready), 32'(4'b0001));
        tick();
        in_valid = '0;
        check("post_rst_data", out_data, 32'h42);
        check("post_rst_valid", 32'(out_valid), 32'(1));
        check("post_rst_cnt", 32'(xfer_cnt), 32'(1));
        out_ready = 1'b1;
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
